// File: rtl/axis_rr_packet_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_packet_arbiter
//
// Packet-level round-robin arbiter for CHANNEL_NUMBER AXI-Stream requesters.
// A winner is chosen in IDLE, starting the search just above the previous
// winner. The grant (mux select) is then held for a whole packet. It is
// released on the TLAST handshake at the mux output. At least one IDLE cycle
// always separates two grants.
//
// Optional feature macro: AXIS_ARB_PMU_EN
//   Adds per-channel saturating counters for completed packets and for
//   waiting cycles. It also adds a synchronous pmu_clr input. Arbitration is
//   the same with or without the macro.
//
// Ports
//   ACLK          in   clock, rising edge
//   ARESETn       in   asynchronous active-low reset
//   in_tvalid     in   [CHANNEL_NUMBER]     TVALID of each requester
//   out_tvalid    in   TVALID at mux output
//   out_tready    in   TREADY at mux output
//   out_tlast     in   TLAST at mux output
//   en            out  mux enable (registered)
//   ctrl          out  [CHANNEL_NUMBER_WIDTH] granted channel index (registered)
//   busy          out  grant held (registered)
//   pmu_clr       in   clear all PMU counters            (AXIS_ARB_PMU_EN)
//   pmu_pkt_cnt   out  [CHANNEL_NUMBER][PMU_COUNTER_WIDTH] packets per channel
//   pmu_wait_cnt  out  [CHANNEL_NUMBER][PMU_COUNTER_WIDTH] wait cycles per channel
// ---------------------------------------------------------------------------
module axis_rr_packet_arbiter #(
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int PMU_COUNTER_WIDTH    = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESETn,
  input  logic [CHANNEL_NUMBER-1:0]       in_tvalid,
  input  logic                            out_tvalid,
  input  logic                            out_tready,
  input  logic                            out_tlast,
  output logic                            en,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl,
  output logic                            busy
`ifdef AXIS_ARB_PMU_EN
  ,
  input  logic                                                pmu_clr,
  output logic [CHANNEL_NUMBER-1:0][PMU_COUNTER_WIDTH-1:0]    pmu_pkt_cnt,
  output logic [CHANNEL_NUMBER-1:0][PMU_COUNTER_WIDTH-1:0]    pmu_wait_cnt
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Channel count in the widened index domain used by the wrap-around search.
  localparam logic [CHANNEL_NUMBER_WIDTH:0]   CH_NUM  = (CHANNEL_NUMBER_WIDTH+1)'(CHANNEL_NUMBER);
  // Reset value of last_grant: the highest channel, so channel 0 wins first.
  localparam logic [CHANNEL_NUMBER_WIDTH-1:0] LAST_CH = CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1);

  logic [0:0]                      state_r;
  logic [0:0]                      state_nxt_s;
  logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl_r;
  logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl_nxt_s;
  logic [CHANNEL_NUMBER_WIDTH-1:0] last_grant_r;
  logic [CHANNEL_NUMBER_WIDTH-1:0] last_grant_nxt_s;
  logic                            en_r;
  logic                            busy_r;
  logic [CHANNEL_NUMBER_WIDTH-1:0] pick_s;
  logic                            release_s;

  // First requesting channel above 'last', wrapping modulo CHANNEL_NUMBER.
  // The loop runs from the farthest offset down to the nearest, so the
  // nearest requester is the one assigned last.
  function automatic logic [CHANNEL_NUMBER_WIDTH-1:0] rr_pick(
    input logic [CHANNEL_NUMBER-1:0]       req,
    input logic [CHANNEL_NUMBER_WIDTH-1:0] last
  );
    logic [CHANNEL_NUMBER_WIDTH:0] idx;
    rr_pick = last;
    for (int k = CHANNEL_NUMBER; k >= 1; k--) begin
      idx = {1'b0, last} + (CHANNEL_NUMBER_WIDTH+1)'(k);
      if (idx >= CH_NUM) begin
        idx = idx - CH_NUM;
      end else begin
        idx = idx;
      end
      if (req[idx[CHANNEL_NUMBER_WIDTH-1:0]]) begin
        rr_pick = idx[CHANNEL_NUMBER_WIDTH-1:0];
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  assign pick_s    = rr_pick(in_tvalid, last_grant_r);
  assign release_s = (state_r == GRANT) & out_tvalid & out_tready & out_tlast;

  // Next-state logic: arbitrate in IDLE, hold the grant until the TLAST handshake.
  always_comb begin
    state_nxt_s      = state_r;
    ctrl_nxt_s       = ctrl_r;
    last_grant_nxt_s = last_grant_r;
    case (state_r)
      IDLE: begin
        if (|in_tvalid) begin
          state_nxt_s      = GRANT;
          ctrl_nxt_s       = pick_s;
          last_grant_nxt_s = pick_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM, select and registered enable/busy. The outputs follow the next state,
  // so they match the FSM state in every cycle.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r      <= IDLE;
      ctrl_r       <= '0;
      last_grant_r <= LAST_CH;
      en_r         <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      ctrl_r       <= ctrl_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      en_r         <= (state_nxt_s == GRANT);
      busy_r       <= (state_nxt_s == GRANT);
    end
  end

  assign en   = en_r;
  assign busy = busy_r;
  assign ctrl = ctrl_r;

`ifdef AXIS_ARB_PMU_EN
  localparam logic [PMU_COUNTER_WIDTH-1:0] PMU_MAX = {PMU_COUNTER_WIDTH{1'b1}};
  localparam logic [PMU_COUNTER_WIDTH-1:0] PMU_ONE = PMU_COUNTER_WIDTH'(1);

  logic [CHANNEL_NUMBER-1:0][PMU_COUNTER_WIDTH-1:0] pkt_cnt_r;
  logic [CHANNEL_NUMBER-1:0][PMU_COUNTER_WIDTH-1:0] wait_cnt_r;

  for (genvar i = 0; i < CHANNEL_NUMBER; i++) begin : g_pmu
    logic pkt_inc_s;
    logic wait_inc_s;

    assign pkt_inc_s  = release_s & (ctrl_r == CHANNEL_NUMBER_WIDTH'(i));
    assign wait_inc_s = in_tvalid[i] & ~((state_r == GRANT) & (ctrl_r == CHANNEL_NUMBER_WIDTH'(i)));

    // Saturating per-channel counters; clear wins over a simultaneous increment.
    always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
        pkt_cnt_r[i]  <= '0;
        wait_cnt_r[i] <= '0;
      end else if (pmu_clr) begin
        pkt_cnt_r[i]  <= '0;
        wait_cnt_r[i] <= '0;
      end else begin
        if (pkt_inc_s && (pkt_cnt_r[i] != PMU_MAX)) begin
          pkt_cnt_r[i] <= pkt_cnt_r[i] + PMU_ONE;
        end else begin
          pkt_cnt_r[i] <= pkt_cnt_r[i];
        end
        if (wait_inc_s && (wait_cnt_r[i] != PMU_MAX)) begin
          wait_cnt_r[i] <= wait_cnt_r[i] + PMU_ONE;
        end else begin
          wait_cnt_r[i] <= wait_cnt_r[i];
        end
      end
    end
  end

  assign pmu_pkt_cnt  = pkt_cnt_r;
  assign pmu_wait_cnt = wait_cnt_r;
`endif

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
module tb_axis_rr_packet_arbiter;

  localparam int N  = 5;
  localparam int CW = 3;
`ifdef AXIS_ARB_PMU_EN
  localparam int PW = 4;
`else
  localparam int PW = 16;
`endif
  localparam int PMAX = (1 << PW) - 1;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b1;
  logic [N-1:0]  in_tvalid = '0;
  logic          out_tvalid = 1'b0;
  logic          out_tready = 1'b0;
  logic          out_tlast = 1'b0;
  logic          en;
  logic [CW-1:0] ctrl;
  logic          busy;
`ifdef AXIS_ARB_PMU_EN
  logic                   pmu_clr = 1'b0;
  logic [N-1:0][PW-1:0]   pmu_pkt_cnt;
  logic [N-1:0][PW-1:0]   pmu_wait_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic          m_busy;
  logic [CW-1:0] m_ctrl;
  int            m_last;
  int            m_pkt  [N];
  int            m_wait [N];

  axis_rr_packet_arbiter #(
    .CHANNEL_NUMBER       (N),
    .CHANNEL_NUMBER_WIDTH (CW),
    .PMU_COUNTER_WIDTH    (PW)
  ) dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .in_tvalid    (in_tvalid),
    .out_tvalid   (out_tvalid),
    .out_tready   (out_tready),
    .out_tlast    (out_tlast),
    .en           (en),
    .ctrl         (ctrl),
    .busy         (busy)
`ifdef AXIS_ARB_PMU_EN
    ,
    .pmu_clr      (pmu_clr),
    .pmu_pkt_cnt  (pmu_pkt_cnt),
    .pmu_wait_cnt (pmu_wait_cnt)
`endif
  );

  always #5 ACLK = ~ACLK;

  function automatic int rr_winner(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_ctrl = '0;
    m_last = N - 1;
    for (int i = 0; i < N; i++) begin
      m_pkt[i]  = 0;
      m_wait[i] = 0;
    end
  endtask

  task automatic model_update();
    logic rel;
    int   w;
    rel = m_busy && out_tvalid && out_tready && out_tlast;
`ifdef AXIS_ARB_PMU_EN
    for (int i = 0; i < N; i++) begin
      if (pmu_clr) begin
        m_pkt[i]  = 0;
        m_wait[i] = 0;
      end else begin
        if (in_tvalid[i] && !(m_busy && (int'(m_ctrl) == i)) && m_wait[i] < PMAX) m_wait[i]++;
        if (rel && (int'(m_ctrl) == i) && m_pkt[i] < PMAX) m_pkt[i]++;
      end
    end
`endif
    if (!m_busy) begin
      if (in_tvalid != '0) begin
        w      = rr_winner(in_tvalid, m_last);
        m_ctrl = CW'(w);
        m_last = w;
        m_busy = 1'b1;
      end
    end else if (rel) begin
      m_busy = 1'b0;
    end
  endtask

  // One clock: model sees the inputs that were applied before the edge.
  task automatic step();
    @(posedge ACLK);
    if (ARESETn) model_update();
    #1;
  endtask

  task automatic drive_idle();
    in_tvalid  = '0;
    out_tvalid = 1'b0;
    out_tready = 1'b0;
    out_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
`ifdef AXIS_ARB_PMU_EN
    pmu_clr = 1'b0;
`endif
    ARESETn = 1'b0;
    model_reset();
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    ARESETn = 1'b0;
    #1;
    tests_run++;
    if (en !== 1'b0 || busy !== 1'b0 || ctrl !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state: en=%b busy=%b ctrl=%0d, want 0 0 0", en, busy, ctrl);
    end
    model_reset();
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    step();
    tests_run++;
    if (en !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle_no_req: en=%b busy=%b, want 0 0", en, busy);
    end
  endtask

  task automatic test_single_packet();
    do_reset();
    in_tvalid = 5'b00100;
    step();
    tests_run++;
    if (en !== 1'b1 || busy !== 1'b1 || ctrl !== 3'd2) begin
      tests_failed++;
      $display("FAIL single_grant: en=%b busy=%b ctrl=%0d, want 1 1 2", en, busy, ctrl);
    end
    in_tvalid  = '0;
    out_tvalid = 1'b1;
    out_tready = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      out_tlast = (b == 3);
      step();
      tests_run++;
      if (en !== (b != 3) || ctrl !== 3'd2) begin
        tests_failed++;
        $display("FAIL single_beat%0d: en=%b ctrl=%0d, want %b 2", b, en, ctrl, (b != 3));
      end
    end
    drive_idle();
  endtask

  task automatic test_round_robin();
    int exp_order [6] = '{0, 1, 2, 3, 4, 0};
    do_reset();
    in_tvalid  = 5'b11111;
    out_tvalid = 1'b1;
    out_tready = 1'b1;
    out_tlast  = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step();
      tests_run++;
      if (en !== ((j % 2) == 0) || ctrl !== CW'(exp_order[j / 2])) begin
        tests_failed++;
        $display("FAIL rr_order step%0d: en=%b ctrl=%0d, want %b %0d",
                 j, en, ctrl, ((j % 2) == 0), exp_order[j / 2]);
      end
    end
    drive_idle();
  endtask

  task automatic test_hold_no_ready();
    do_reset();
    in_tvalid = 5'b00010;
    step();
    tests_run++;
    if (en !== 1'b1 || ctrl !== 3'd1) begin
      tests_failed++;
      $display("FAIL hold_grant: en=%b ctrl=%0d, want 1 1", en, ctrl);
    end
    in_tvalid  = '0;
    out_tvalid = 1'b1;
    out_tlast  = 1'b1;
    out_tready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      tests_run++;
      if (en !== 1'b1 || busy !== 1'b1 || ctrl !== 3'd1) begin
        tests_failed++;
        $display("FAIL hold_no_ready c%0d: en=%b busy=%b ctrl=%0d, want 1 1 1", c, en, busy, ctrl);
      end
    end
    out_tready = 1'b1;
    step();
    tests_run++;
    if (en !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_release: en=%b busy=%b, want 0 0", en, busy);
    end
    drive_idle();
  endtask

  task automatic test_ignore_midpacket();
    do_reset();
    in_tvalid = 5'b01000;
    step();
    tests_run++;
    if (en !== 1'b1 || ctrl !== 3'd3) begin
      tests_failed++;
      $display("FAIL mid_grant3: en=%b ctrl=%0d, want 1 3", en, ctrl);
    end
    in_tvalid  = 5'b00001;
    out_tvalid = 1'b1;
    out_tready = 1'b1;
    out_tlast  = 1'b0;
    for (int b = 0; b < 2; b++) begin
      step();
      tests_run++;
      if (en !== 1'b1 || ctrl !== 3'd3) begin
        tests_failed++;
        $display("FAIL mid_hold b%0d: en=%b ctrl=%0d, want 1 3", b, en, ctrl);
      end
    end
    out_tlast = 1'b1;
    step();
    tests_run++;
    if (en !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_idle_gap: en=%b, want 0", en);
    end
    out_tvalid = 1'b0;
    out_tlast  = 1'b0;
    step();
    tests_run++;
    if (en !== 1'b1 || ctrl !== 3'd0) begin
      tests_failed++;
      $display("FAIL mid_next_grant: en=%b ctrl=%0d, want 1 0", en, ctrl);
    end
    in_tvalid  = '0;
    out_tvalid = 1'b1;
    out_tlast  = 1'b1;
    step();
    drive_idle();
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    in_tvalid = 5'b10000;
    step();
    tests_run++;
    if (en !== 1'b1 || ctrl !== 3'd4) begin
      tests_failed++;
      $display("FAIL rstmid_grant4: en=%b ctrl=%0d, want 1 4", en, ctrl);
    end
    out_tvalid = 1'b1;
    out_tready = 1'b1;
    step();
    #2 ARESETn = 1'b0;
    #1;
    tests_run++;
    if (en !== 1'b0 || busy !== 1'b0 || ctrl !== 3'd0) begin
      tests_failed++;
      $display("FAIL rstmid_drop: en=%b busy=%b ctrl=%0d, want 0 0 0", en, busy, ctrl);
    end
    drive_idle();
    model_reset();
    @(posedge ACLK);
    #1 ARESETn = 1'b1;
    in_tvalid = 5'b10001;
    step();
    tests_run++;
    if (en !== 1'b1 || ctrl !== 3'd0) begin
      tests_failed++;
      $display("FAIL rstmid_ch0_first: en=%b ctrl=%0d, want 1 0", en, ctrl);
    end
    in_tvalid  = '0;
    out_tvalid = 1'b1;
    out_tready = 1'b1;
    out_tlast  = 1'b1;
    step();
    drive_idle();
  endtask

`ifdef AXIS_ARB_PMU_EN
  task automatic test_pmu();
    do_reset();
    in_tvalid = 5'b00001;
    step();
    in_tvalid  = 5'b00101;
    out_tvalid = 1'b1;
    out_tready = 1'b1;
    out_tlast  = 1'b0;
    repeat (20) step();
    tests_run++;
    if (pmu_wait_cnt[2] !== 4'd15 || pmu_wait_cnt[0] !== 4'd1) begin
      tests_failed++;
      $display("FAIL pmu_wait_sat: wait2=%0d wait0=%0d, want 15 1", pmu_wait_cnt[2], pmu_wait_cnt[0]);
    end
    pmu_clr = 1'b1;
    step();
    pmu_clr = 1'b0;
    tests_run++;
    if (pmu_wait_cnt[2] !== 4'd0 || pmu_wait_cnt[0] !== 4'd0) begin
      tests_failed++;
      $display("FAIL pmu_clr: wait2=%0d wait0=%0d, want 0 0", pmu_wait_cnt[2], pmu_wait_cnt[0]);
    end
    in_tvalid = '0;
    out_tlast = 1'b1;
    step();
    tests_run++;
    if (pmu_pkt_cnt[0] !== 4'd1 || pmu_pkt_cnt[2] !== 4'd0) begin
      tests_failed++;
      $display("FAIL pmu_pkt: pkt0=%0d pkt2=%0d, want 1 0", pmu_pkt_cnt[0], pmu_pkt_cnt[2]);
    end
    drive_idle();
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      in_tvalid  = N'($urandom_range(0, (1 << N) - 1));
      out_tvalid = ($urandom_range(0, 3) != 0);
      out_tready = ($urandom_range(0, 3) != 0);
      out_tlast  = ($urandom_range(0, 2) == 0);
`ifdef AXIS_ARB_PMU_EN
      pmu_clr    = ($urandom_range(0, 63) == 0);
`endif
      step();
      tests_run++;
      if (en !== m_busy || busy !== m_busy || ctrl !== m_ctrl) begin
        tests_failed++;
        $display("FAIL random c%0d: en=%b busy=%b ctrl=%0d, want %b %b %0d",
                 c, en, busy, ctrl, m_busy, m_busy, m_ctrl);
      end
`ifdef AXIS_ARB_PMU_EN
      for (int i = 0; i < N; i++) begin
        tests_run++;
        if (pmu_pkt_cnt[i] !== PW'(m_pkt[i]) || pmu_wait_cnt[i] !== PW'(m_wait[i])) begin
          tests_failed++;
          $display("FAIL random_pmu c%0d ch%0d: pkt=%0d wait=%0d, want %0d %0d",
                   c, i, pmu_pkt_cnt[i], pmu_wait_cnt[i], m_pkt[i], m_wait[i]);
        end
      end
`endif
    end
`ifdef AXIS_ARB_PMU_EN
    pmu_clr = 1'b0;
`endif
    drive_idle();
  endtask

  initial begin
    #3;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_hold_no_ready();
    test_ignore_midpacket();
    test_reset_midpacket();
`ifdef AXIS_ARB_PMU_EN
    test_pmu();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axis_rr_packet_arbiter.md
AXIS_RR_PACKET_ARBITER -- requirements
Module: axis_rr_packet_arbiter

Interface
REQ-001 The block SHALL have parameter CHANNEL_NUMBER, default 5, giving the number of requesting AXI-Stream channels.
REQ-002 The block SHALL have parameter CHANNEL_NUMBER_WIDTH, default $clog2(CHANNEL_NUMBER), giving the width of the grant index.
REQ-003 The block SHALL have parameter PMU_COUNTER_WIDTH, default 16, giving the PMU counter width (used only with AXIS_ARB_PMU_EN).
REQ-004 ACLK  input  1  single clock; all state changes on its rising edge.
REQ-005 ARESETn  input  1  reset, asynchronous assert, active-low.
REQ-006 in_tvalid  input  CHANNEL_NUMBER  TVALID of each requester, bit i = channel i.
REQ-007 out_tvalid  input  1  TVALID at the mux output.
REQ-008 out_tready  input  1  TREADY at the mux output.
REQ-009 out_tlast  input  1  TLAST at the mux output; marks the final beat of a packet.
REQ-010 en  output  1  mux enable.
REQ-011 ctrl  output  CHANNEL_NUMBER_WIDTH  mux select (granted channel index).
REQ-012 busy  output  1  high while a packet grant is held.
REQ-013 pmu_clr  input  1  synchronous clear of all PMU counters (only with AXIS_ARB_PMU_EN).
REQ-014 pmu_pkt_cnt  output  CHANNEL_NUMBER x PMU_COUNTER_WIDTH  completed packets per channel (only with AXIS_ARB_PMU_EN).
REQ-015 pmu_wait_cnt  output  CHANNEL_NUMBER x PMU_COUNTER_WIDTH  cycles each channel waited with TVALID high and no grant (only with AXIS_ARB_PMU_EN).

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-017 In IDLE, en, busy = 0; ctrl holds its last registered value.
REQ-018 In IDLE with any in_tvalid bit set, the block SHALL select the first set bit searching upward from last_grant+1 modulo CHANNEL_NUMBER, register it into ctrl and last_grant, and enter GRANT on the next edge.
REQ-019 Arbitration latency SHALL be exactly one cycle: request seen in cycle N -> en=1 with ctrl=winner from cycle N+1.
REQ-020 In IDLE with no in_tvalid bit set, the FSM SHALL remain in IDLE and last_grant SHALL not change.
REQ-021 In GRANT, en = busy = 1 and ctrl SHALL remain constant regardless of any in_tvalid change.
REQ-022 GRANT SHALL exit to IDLE on the edge where out_tvalid & out_tready & out_tlast = 1; at least one IDLE cycle separates consecutive packets.
REQ-023 A beat with out_tlast=1 but out_tready=0 or out_tvalid=0 SHALL NOT release the grant.
REQ-024 Requests from non-granted channels during GRANT SHALL be ignored until the next IDLE cycle; no request is dropped, it is re-evaluated there.
REQ-025 A single continuously requesting channel SHALL receive consecutive grants with one IDLE cycle between them.
REQ-026 Each channel with in_tvalid held high SHALL be granted within CHANNEL_NUMBER packet completions.

Reset
REQ-027 On ARESETn low, asynchronously: FSM = IDLE, en = 0, busy = 0, ctrl = 0, last_grant = CHANNEL_NUMBER-1 (so channel 0 has first priority).
REQ-028 Reset asserted mid-packet SHALL drop en immediately and abandon the grant; no state survives reset.
REQ-029 With AXIS_ARB_PMU_EN, all PMU counters SHALL reset to 0.

Configuration
REQ-030 Macro AXIS_ARB_PMU_EN SHALL compile in pmu_clr, pmu_pkt_cnt, pmu_wait_cnt and their counters; without it these ports and registers SHALL not exist and arbitration behaviour SHALL be identical.
REQ-031 pmu_pkt_cnt[i] SHALL increment by 1 on each grant release (REQ-022) while ctrl = i.
REQ-032 pmu_wait_cnt[i] SHALL increment by 1 each cycle in_tvalid[i] = 1 and not (GRANT and ctrl = i).
REQ-033 All PMU counters SHALL saturate at all-ones and never wrap.
REQ-034 pmu_clr SHALL zero all counters on the next edge, taking priority over a simultaneous increment.

Verification
REQ-035 Reset, then in_tvalid=5'b00100 in cycle 0 -> ctrl=2, en=1 from cycle 1; 3-beat packet with TLAST on beat 3 -> en=0 the following cycle.
REQ-036 in_tvalid=5'b11111 held, 1-beat packets, always ready -> grant order 0,1,2,3,4,0 with one IDLE cycle between grants.
REQ-037 Granted channel 1, out_tlast=1 with out_tready=0 for 4 cycles -> grant held; release only on the cycle out_tready=1.
REQ-038 Grant on channel 3, in_tvalid=5'b00001 raised mid-packet -> ctrl stays 3 until TLAST handshake, then channel 0 granted after one IDLE cycle.
REQ-039 ARESETn pulsed low mid-packet on channel 4 -> en=0 immediately; after release, in_tvalid=5'b10001 -> channel 0 granted first.
REQ-040 With AXIS_ARB_PMU_EN, PMU_COUNTER_WIDTH=4, channel 2 waits 20 cycles -> pmu_wait_cnt[2]=15 (saturated); pmu_clr -> 0 next cycle.
